// File: rtl/wavegen_config_rx.sv
// Serial configuration receiver for the waveform generator: deframes a 13-bit
// strobed frame and loads frequency word, waveform select and amplitude select.
module wavegen_config_rx #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serIn,
  input  logic       serValid,
  output logic       ld,
  output logic [4:0] parIn,
  output logic [2:0] mux_sel,
  output logic [1:0] Amp_Sel,
  output logic       busy,
  output logic       frame_err
);

  localparam int unsigned CNT_W  = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned DATA_W = 10;
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   shift_reg;
  logic [3:0]          bit_cnt;
  logic [CNT_W-1:0]    idle_cnt;
  logic                parity_ok;

  logic data_par_c;
  logic mux_ok_c;
  logic timeout_hit_c;
  logic accept_c;

  // Frame qualification, evaluated against the completed shift register
  always_comb begin
    data_par_c    = ^shift_reg;
    mux_ok_c      = (shift_reg[4:2] <= 3'd5);
    timeout_hit_c = (state != S_IDLE) && !serValid && (idle_cnt >= IDLE_LIM);
    accept_c      = serIn && parity_ok && mux_ok_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      parity_ok <= 1'b0;
      ld        <= 1'b0;
      parIn     <= '0;
      mux_sel   <= '0;
      Amp_Sel   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ld        <= 1'b0;
      frame_err <= 1'b0;

      // Inter-strobe gap counter; only meaningful inside a frame
      if (state == S_IDLE || serValid) begin
        idle_cnt <= '0;
      end else if (idle_cnt != '1) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end

      if (timeout_hit_c) begin
        state     <= S_IDLE;
        idle_cnt  <= '0;
        busy      <= 1'b0;
        frame_err <= 1'b1;
      end else if (serValid) begin
        case (state)
          S_IDLE: begin
            if (!serIn) begin
              state   <= S_DATA;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          S_DATA: begin
            shift_reg <= {shift_reg[DATA_W-2:0], serIn};
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= S_PARITY;
            end
          end
          S_PARITY: begin
            parity_ok <= (serIn == data_par_c);
            state     <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (accept_c) begin
              parIn   <= shift_reg[9:5];
              mux_sel <= shift_reg[4:2];
              Amp_Sel <= shift_reg[1:0];
              ld      <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
